ucstats_table: RTL and testbench
================================

# ucstats_table

Responder side of the uC stats read interface. It holds the 64×32 SFP diagnostic table, which covers 2 channels × 32 entries. The uC host writes the table. Link engines read it in daisy-chain order: each engine drives a registered 6-bit address, and this block merges those addresses and returns the data word exactly 3 cycles later. It also serves uC readback reads in idle address slots, and clears the table after reset.

## Interface
- NUM_LE, 8: number of link engine address inputs merged.
- clk  in  1: single clock.
- rst  in  1: synchronous, active-high reset.
- iLE_UCSTATS_ADDR  in  NUM_LE*6: per-engine {ch_id, addr[4:0]}. Slice i is bits [6i+5:6i]. Idle engines drive 0.
- oUCSTATS_DATA  out  32: read data, broadcast to all engines.
- iUC_WR_EN  in  1: write request level, held until ack.
- iUC_WR_ADDR  in  6: write address.
- iUC_WR_DATA  in  32: write data.
- iUC_WR_BE  in  4: byte enables. Bit k covers data[8k+7:8k].
- oUC_WR_ACK  out  1: one-cycle pulse; the write has committed.
- iUC_RD_EN  in  1: readback request level, held until valid.
- iUC_RD_ADDR  in  6: readback address.
- oUC_RD_DATA  out  32: readback data.
- oUC_RD_VALID  out  1: one-cycle pulse qualifying oUC_RD_DATA.
- oINIT_DONE  out  1: table clear complete.
- oUCSTATS_COLLISION  out  1: sticky merge-error flag. Present only with UCSTATS_COLLISION_CHK_EN.

## Operation
- Reset values: oUCSTATS_DATA=0, oUC_WR_ACK=0, oUC_RD_DATA=0, oUC_RD_VALID=0, oINIT_DONE=0, oUCSTATS_COLLISION=0. Table contents are not reset directly; the init sweep clears them.
- Init FSM, states INIT → RUN:
  - INIT: a 6-bit counter starts at 0 and writes 0 to one entry per cycle.
  - After entry 63 is written, the FSM moves to RUN and oINIT_DONE rises. That is 64 cycles after rst deasserts.
  - rst asserted in any state returns the FSM to INIT with the counter at 0 and restarts the sweep.
- In INIT:
  - uC writes and reads are not accepted; requests stay pending.
  - The LE read pipeline still runs and returns the current, partially cleared contents.
- Merge: merged_addr_r is registered as the bitwise OR of all NUM_LE slices. The chain guarantees at most one engine is non-idle at a time.
- Read pipeline:
  - Stage 1 registers merged_addr_r.
  - Stage 2 registers mem[merged_addr_r] into rd_r.
  - Stage 3 registers rd_r into oUCSTATS_DATA.
- uC write, in RUN only:
  - The write is accepted when iUC_WR_EN=1 and oUC_WR_ACK=0.
  - Bytes with BE=1 are updated on that clock edge; bytes with BE=0 are unchanged.
  - oUC_WR_ACK pulses on the next cycle.
  - iUC_WR_EN seen while ack is high is ignored, so a level held one cycle too long does not write twice.
  - BE=0000 is still acked, with no data change.
- uC readback, in RUN only:
  - A pending request is granted in a cycle where merged_addr_r[4:0]==0 (idle slot). The stage-2 read port then uses iUC_RD_ADDR instead.
  - In that slot, stage 2 forwards 0 to the LE path, so oUCSTATS_DATA carries 0.
  - oUC_RD_DATA is loaded and oUC_RD_VALID pulses 2 cycles after the grant.
  - No new grant is made while a grant is in flight.
- Collision, same cycle and same address:
  - A stage-2 read returns the pre-write contents (read-old).
  - The next read of that entry returns the new data.
- The init-sweep write and the uC write are never simultaneous, because uC writes are blocked in INIT.

## Timing
- LE address at a source register output in cycle T gives oUCSTATS_DATA valid in cycle T+3. This latency is fixed and holds for every address, including idle address 0.
- uC write: accepted at edge E, ack high in cycle E+1. A new request is accepted no earlier than E+2, so peak throughput is 1 write per 2 cycles.
- uC read: grant at G gives valid at G+2. Worst-case wait for a grant is unbounded only if the engines never issue an idle address. The daisy-chain idle gaps bound it in practice.
- The write port and the read port are independent, so a write and an LE read of the same entry in the same cycle both proceed.

## Configuration
- UCSTATS_COLLISION_CHK_EN defined:
  - Each cycle, count the slices with a nonzero address.
  - If the count is greater than 1, set oUCSTATS_COLLISION on the next cycle. It stays set until rst.
  - The merge itself is unaffected and remains the OR.
- UCSTATS_COLLISION_CHK_EN undefined: port and logic are absent; there is no collision detection.

## Test plan
- Reset, then idle for 70 cycles → oINIT_DONE rises exactly 64 cycles after rst falls. An LE read of 0x0b then returns 0x00000000.
- uC write 0x0b=0xAABBCCDD, BE=1111, then 0x0b=0x11223344, BE=0101 → ack each one cycle later. LE0 drives 0x0b at T and sees 0xAA22CC44 at T+3.
- LE3 drives 0x2d at T while a uC write to 0x2d (data 0xFFFFFFFF, BE=1111) commits at the edge where stage 2 samples that address → the T+3 data is the old value. A second read of 0x2d at T+5 → 0xFFFFFFFF at T+8.
- uC read of 0x0c held while LE0 issues 0x0b, 0x0a, 0x0d, 0x0c, 0x00 → grant only in the 0x00 slot, oUC_RD_VALID 2 cycles later with the correct data. The LE data for that slot is 0.
- Assert rst at sweep count 30, then release → the sweep restarts at 0 and oINIT_DONE comes 64 cycles after release. A uC write held throughout is acked only after oINIT_DONE.
- With UCSTATS_COLLISION_CHK_EN: LE1=0x0a and LE2=0x2a in the same cycle → oUCSTATS_COLLISION=1 next cycle and it stays set. Without the macro, the same stimulus gives data from address 0x2a.

Source files
------------

// File: rtl/ucstats_table.sv
// 64x32 uC stats table: merges link-engine read addresses into a fixed 3-cycle
// read pipeline, serves uC writes/readbacks, and clears itself after reset.
// Optional merge-collision flag is built only with UCSTATS_COLLISION_CHK_EN.
module ucstats_table #(
  parameter int NUM_LE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_LE*6-1:0] iLE_UCSTATS_ADDR,
  output logic [31:0]         oUCSTATS_DATA,
  input  logic                iUC_WR_EN,
  input  logic [5:0]          iUC_WR_ADDR,
  input  logic [31:0]         iUC_WR_DATA,
  input  logic [3:0]          iUC_WR_BE,
  output logic                oUC_WR_ACK,
  input  logic                iUC_RD_EN,
  input  logic [5:0]          iUC_RD_ADDR,
  output logic [31:0]         oUC_RD_DATA,
  output logic                oUC_RD_VALID,
  output logic                oINIT_DONE
`ifdef UCSTATS_COLLISION_CHK_EN
  ,
  output logic                oUCSTATS_COLLISION
`endif
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  initCnt_q, initCnt_d;
  logic        initWrEn;
  logic        runMode;

  logic [31:0] mem_q [64];

  logic [5:0]  mergedAddr_q, mergedAddr_d;
  logic [5:0]  rdAddr;
  logic [31:0] rdWord;
  logic [31:0] rd_q;
  logic [31:0] leData_q;

  logic        wrAccept;
  logic        wrAck_q;

  logic        rdGrant;
  logic        ucRdPend_q;
  logic [31:0] ucRdStage_q;
  logic [31:0] ucRdData_q;
  logic        ucRdValid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      initCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      initCnt_q <= initCnt_d;
    end
  end

  // The sweep clears one entry per cycle; RUN is entered as entry 63 is written.
  always_comb begin
    state_d   = state_q;
    initCnt_d = initCnt_q;
    initWrEn  = 1'b0;
    case (state_q)
      ST_INIT: begin
        initWrEn  = 1'b1;
        initCnt_d = initCnt_q + 6'd1;
        if (initCnt_q == 6'd63) begin
          state_d = ST_RUN;
        end
      end
      default: begin
      end
    endcase
  end

  assign runMode    = (state_q == ST_RUN);
  assign oINIT_DONE = runMode;

  always_comb begin
    mergedAddr_d = '0;
    for (int i = 0; i < NUM_LE; i++) begin
      mergedAddr_d = mergedAddr_d | iLE_UCSTATS_ADDR[6*i +: 6];
    end
  end

  // Ack high blocks re-acceptance, so a request level held one cycle too long
  // cannot commit twice.
  assign wrAccept = runMode & iUC_WR_EN & ~wrAck_q;

  assign rdGrant = runMode & iUC_RD_EN & (mergedAddr_q[4:0] == 5'd0) &
                   ~ucRdPend_q & ~ucRdValid_q;

  assign rdAddr = rdGrant ? iUC_RD_ADDR : mergedAddr_q;
  assign rdWord = mem_q[rdAddr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (initWrEn) begin
        mem_q[initCnt_q] <= '0;
      end else if (wrAccept) begin
        for (int b = 0; b < 4; b++) begin
          if (iUC_WR_BE[b]) begin
            mem_q[iUC_WR_ADDR][8*b +: 8] <= iUC_WR_DATA[8*b +: 8];
          end
        end
      end
    end
  end

  // Borrowed idle slots return 0 on the engine path so every engine read keeps
  // its fixed 3-cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      mergedAddr_q <= '0;
      rd_q         <= '0;
      leData_q     <= '0;
      wrAck_q      <= 1'b0;
      ucRdPend_q   <= 1'b0;
      ucRdStage_q  <= '0;
      ucRdData_q   <= '0;
      ucRdValid_q  <= 1'b0;
    end else begin
      mergedAddr_q <= mergedAddr_d;
      rd_q         <= rdGrant ? 32'd0 : rdWord;
      leData_q     <= rd_q;
      wrAck_q      <= wrAccept;
      ucRdPend_q   <= rdGrant;
      if (rdGrant) begin
        ucRdStage_q <= rdWord;
      end
      if (ucRdPend_q) begin
        ucRdData_q <= ucRdStage_q;
      end
      ucRdValid_q  <= ucRdPend_q;
    end
  end

  assign oUCSTATS_DATA = leData_q;
  assign oUC_WR_ACK    = wrAck_q;
  assign oUC_RD_DATA   = ucRdData_q;
  assign oUC_RD_VALID  = ucRdValid_q;

`ifdef UCSTATS_COLLISION_CHK_EN
  logic anyNz;
  logic multiNz;
  logic collision_q;

  always_comb begin
    anyNz   = 1'b0;
    multiNz = 1'b0;
    for (int i = 0; i < NUM_LE; i++) begin
      if (iLE_UCSTATS_ADDR[6*i +: 6] != 6'd0) begin
        if (anyNz) begin
          multiNz = 1'b1;
        end
        anyNz = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      collision_q <= 1'b0;
    end else if (multiNz) begin
      collision_q <= 1'b1;
    end
  end

  assign oUCSTATS_COLLISION = collision_q;
`endif

endmodule

// File: tb/tb_ucstats_table.sv
// Self-checking bench for ucstats_table: engine reads are scoreboarded with a
// fixed 3-cycle latency, uC write/readback and init sweep checked by hand.
module tb_ucstats_table;

  localparam int NUM_LE = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_LE*6-1:0] leAddr;
  logic [31:0]         oUCSTATS_DATA;
  logic                iUC_WR_EN;
  logic [5:0]          iUC_WR_ADDR;
  logic [31:0]         iUC_WR_DATA;
  logic [3:0]          iUC_WR_BE;
  logic                oUC_WR_ACK;
  logic                iUC_RD_EN;
  logic [5:0]          iUC_RD_ADDR;
  logic [31:0]         oUC_RD_DATA;
  logic                oUC_RD_VALID;
  logic                oINIT_DONE;
`ifdef UCSTATS_COLLISION_CHK_EN
  logic                oUCSTATS_COLLISION;
`endif

  ucstats_table #(.NUM_LE(NUM_LE)) dut (
    .clk               (clk),
    .rst               (rst),
    .iLE_UCSTATS_ADDR  (leAddr),
    .oUCSTATS_DATA     (oUCSTATS_DATA),
    .iUC_WR_EN         (iUC_WR_EN),
    .iUC_WR_ADDR       (iUC_WR_ADDR),
    .iUC_WR_DATA       (iUC_WR_DATA),
    .iUC_WR_BE         (iUC_WR_BE),
    .oUC_WR_ACK        (oUC_WR_ACK),
    .iUC_RD_EN         (iUC_RD_EN),
    .iUC_RD_ADDR       (iUC_RD_ADDR),
    .oUC_RD_DATA       (oUC_RD_DATA),
    .oUC_RD_VALID      (oUC_RD_VALID),
    .oINIT_DONE        (oINIT_DONE)
`ifdef UCSTATS_COLLISION_CHK_EN
    ,
    .oUCSTATS_COLLISION(oUCSTATS_COLLISION)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] exp;
    string       name;
  } sbEntry_t;

  typedef struct {
    int          slot;
    logic [5:0]  addr;
    logic [31:0] exp;
  } leVec_t;

  sbEntry_t    sbQ[$];
  leVec_t      vecs[8];
  logic [31:0] modelMem[64];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops every scoreboard entry due this cycle and compares it with the engine data.
  task automatic checkOutput();
    sbEntry_t e;
    while (sbQ.size() > 0 && sbQ[0].due <= cyc) begin
      e = sbQ.pop_front();
      if (e.due != cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s: got stale entry due %0d expected due %0d", e.name, e.due, cyc);
      end else begin
        checkVal(e.name, oUCSTATS_DATA, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic driveLe(input int slot, input logic [5:0] addr);
    leAddr = '0;
    leAddr[slot*6 +: 6] = addr;
  endtask

  task automatic applyStimulus(input int slot, input logic [5:0] addr, input logic [31:0] exp);
    sbEntry_t e;
    driveLe(slot, addr);
    e.due  = cyc + 3;
    e.exp  = exp;
    e.name = $sformatf("leRd_s%0d_a%02h", slot, addr);
    sbQ.push_back(e);
  endtask

  task automatic drain();
    driveLe(0, 6'd0);
    for (int i = 0; i < 10 && sbQ.size() > 0; i++) begin
      tick();
    end
    if (sbQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic modelWrite(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) modelMem[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic ucWrite(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    checkVal("wrAckIdle", {31'd0, oUC_WR_ACK}, 32'd0);
    iUC_WR_EN   = 1'b1;
    iUC_WR_ADDR = a;
    iUC_WR_DATA = d;
    iUC_WR_BE   = be;
    tick();
    checkVal("wrAck", {31'd0, oUC_WR_ACK}, 32'd1);
    iUC_WR_EN = 1'b0;
    modelWrite(a, d, be);
    tick();
    checkVal("wrAckPulse", {31'd0, oUC_WR_ACK}, 32'd0);
  endtask

  initial begin
    logic [5:0]  seq[10];
    logic [31:0] expv;
    logic [31:0] rdGot;
    int          n;
    int          t0;
    int          validCyc;
    int          validCnt;
    int          ackEarly;

    rst = 1'b1;
    leAddr = '0;
    iUC_WR_EN = 1'b0;
    iUC_WR_ADDR = '0;
    iUC_WR_DATA = '0;
    iUC_WR_BE = '0;
    iUC_RD_EN = 1'b0;
    iUC_RD_ADDR = '0;
    for (int i = 0; i < 64; i++) modelMem[i] = 32'd0;

    tick(); tick(); tick();
    checkVal("rstData", oUCSTATS_DATA, 32'd0);
    checkVal("rstWrAck", {31'd0, oUC_WR_ACK}, 32'd0);
    checkVal("rstRdData", oUC_RD_DATA, 32'd0);
    checkVal("rstRdValid", {31'd0, oUC_RD_VALID}, 32'd0);
    checkVal("rstInitDone", {31'd0, oINIT_DONE}, 32'd0);
`ifdef UCSTATS_COLLISION_CHK_EN
    checkVal("rstCollision", {31'd0, oUCSTATS_COLLISION}, 32'd0);
`endif

    rst = 1'b0;
    n = 0;
    while (!oINIT_DONE && n < 200) begin
      tick();
      n++;
    end
    checkVal("initDoneLatency", n, 64);

    applyStimulus(0, 6'h0b, 32'h0000_0000);
    tick();
    drain();

    ucWrite(6'h0b, 32'hAABBCCDD, 4'b1111);
    ucWrite(6'h0b, 32'h11223344, 4'b0101);
    ucWrite(6'h2d, 32'h12345678, 4'b1111);
    ucWrite(6'h2a, 32'hCAFEF00D, 4'b1111);
    ucWrite(6'h0c, 32'h0C0C0C0C, 4'b1111);
    ucWrite(6'h0a, 32'h0A0A0A0A, 4'b1111);
    ucWrite(6'h0d, 32'h0D0D0D0D, 4'b1111);
    ucWrite(6'h0d, 32'hFFFFFFFF, 4'b0000);
    ucWrite(6'h00, 32'h5A5A5A5A, 4'b1111);

    vecs[0] = '{0, 6'h0b, 32'hAA22CC44};
    vecs[1] = '{3, 6'h2d, 32'h12345678};
    vecs[2] = '{1, 6'h2a, 32'hCAFEF00D};
    vecs[3] = '{7, 6'h0c, 32'h0C0C0C0C};
    vecs[4] = '{5, 6'h00, 32'h5A5A5A5A};
    vecs[5] = '{2, 6'h0a, 32'h0A0A0A0A};
    vecs[6] = '{6, 6'h3f, 32'h00000000};
    vecs[7] = '{4, 6'h0d, 32'h0D0D0D0D};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].slot, vecs[i].addr, vecs[i].exp);
      tick();
    end
    drain();

    // Write commits at the same edge stage 2 samples 0x2d: old data, then new.
    applyStimulus(3, 6'h2d, 32'h12345678);
    tick();
    driveLe(0, 6'd0);
    iUC_WR_EN   = 1'b1;
    iUC_WR_ADDR = 6'h2d;
    iUC_WR_DATA = 32'hFFFFFFFF;
    iUC_WR_BE   = 4'b1111;
    tick();
    checkVal("collWrAck", {31'd0, oUC_WR_ACK}, 32'd1);
    iUC_WR_EN = 1'b0;
    modelWrite(6'h2d, 32'hFFFFFFFF, 4'b1111);
    tick();
    tick();
    tick();
    applyStimulus(3, 6'h2d, 32'hFFFFFFFF);
    tick();
    drain();

    // Readback may only borrow the idle slot issued after 0x0c.
    seq[0] = 6'h0b; seq[1] = 6'h0a; seq[2] = 6'h0d; seq[3] = 6'h0c; seq[4] = 6'h00;
    for (int k = 5; k < 10; k++) seq[k] = 6'h00;
    t0 = cyc;
    validCyc = -1;
    validCnt = 0;
    rdGot = '0;
    for (int k = 0; k < 10; k++) begin
      expv = (k == 4) ? 32'd0 : modelMem[seq[k]];
      applyStimulus(0, seq[k], expv);
      if (k == 1) begin
        iUC_RD_EN   = 1'b1;
        iUC_RD_ADDR = 6'h0c;
      end
      if (oUC_RD_VALID) begin
        validCnt++;
        if (validCyc < 0) begin
          validCyc = cyc;
          rdGot = oUC_RD_DATA;
        end
        iUC_RD_EN = 1'b0;
      end
      tick();
    end
    iUC_RD_EN = 1'b0;
    drain();
    checkVal("rdValidCount", validCnt, 1);
    checkVal("rdValidCycle", validCyc - t0, 7);
    checkVal("rdData", rdGot, 32'h0C0C0C0C);

    // Two engines active at once: merge stays the OR of both slices.
    leAddr = '0;
    leAddr[6 +: 6]  = 6'h0a;
    leAddr[12 +: 6] = 6'h2a;
    begin
      sbEntry_t e;
      e.due = cyc + 3;
      e.exp = 32'hCAFEF00D;
      e.name = "leMergeOr";
      sbQ.push_back(e);
    end
`ifdef UCSTATS_COLLISION_CHK_EN
    checkVal("collBefore", {31'd0, oUCSTATS_COLLISION}, 32'd0);
`endif
    tick();
    driveLe(0, 6'd0);
`ifdef UCSTATS_COLLISION_CHK_EN
    checkVal("collSet", {31'd0, oUCSTATS_COLLISION}, 32'd1);
`endif
    tick();
    tick();
`ifdef UCSTATS_COLLISION_CHK_EN
    checkVal("collSticky", {31'd0, oUCSTATS_COLLISION}, 32'd1);
`endif
    drain();

    // Reset mid-sweep with a uC write held across both resets.
    rst = 1'b1;
    iUC_WR_EN   = 1'b1;
    iUC_WR_ADDR = 6'h15;
    iUC_WR_DATA = 32'h13579BDF;
    iUC_WR_BE   = 4'b1111;
    tick();
    tick();
    checkVal("rst2InitDone", {31'd0, oINIT_DONE}, 32'd0);
`ifdef UCSTATS_COLLISION_CHK_EN
    checkVal("rst2Collision", {31'd0, oUCSTATS_COLLISION}, 32'd0);
`endif
    rst = 1'b0;
    ackEarly = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (oUC_WR_ACK) ackEarly = 1;
    end
    checkVal("midSweepDone", {31'd0, oINIT_DONE}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) modelMem[i] = 32'd0;
    n = 0;
    while (!oINIT_DONE && n < 200) begin
      tick();
      n++;
      if (oUC_WR_ACK) ackEarly = 1;
    end
    checkVal("restartDoneLatency", n, 64);
    checkVal("heldWrNoEarlyAck", ackEarly, 0);
    tick();
    checkVal("heldWrAck", {31'd0, oUC_WR_ACK}, 32'd1);
    iUC_WR_EN = 1'b0;
    modelWrite(6'h15, 32'h13579BDF, 4'b1111);
    tick();
    checkVal("heldWrAckPulse", {31'd0, oUC_WR_ACK}, 32'd0);

    applyStimulus(0, 6'h15, 32'h13579BDF);
    tick();
    applyStimulus(1, 6'h0b, 32'h00000000);
    tick();
    applyStimulus(2, 6'h2d, 32'h00000000);
    tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
